// File: rtl/ysyx_22050550_mul_booth_r4_if.sv
// Request/result handshake bundle between the EXU and the radix-4 Booth multiplier.
interface ysyx_22050550_mul_booth_r4_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic            in_word;
    logic [1:0]      in_sign;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result_hi;
    logic [XLEN-1:0] result_lo;

    modport master (
        output in_valid, in_word, in_sign, in_a, in_b, flush, out_ready,
        input  in_ready, out_valid, result_hi, result_lo
    );

    modport slave (
        input  in_valid, in_word, in_sign, in_a, in_b, flush, out_ready,
        output in_ready, out_valid, result_hi, result_lo
    );
endinterface

// File: rtl/ysyx_22050550_mul_booth_r4.sv
// Iterative radix-4 Booth multiplier, one digit per cycle, full 2*XLEN product.
// Optional early termination when YSYX_22050550_MUL_EARLYEXIT_EN is defined.
module ysyx_22050550_mul_booth_r4 #(
    parameter int XLEN = 64,
    parameter int WLEN = XLEN / 2
) (
    input  logic                              clock,
    input  logic                              reset,
    ysyx_22050550_mul_booth_r4_if.slave       mul
);
    // The two guard bits above 2*XLEN never reach the result, so ACC/M are
    // kept modulo 2^(2*XLEN); the low bits are unaffected by the truncation.
    localparam int AW = 2 * XLEN;
    localparam int QW = XLEN + 2;
    localparam int CW = $clog2(XLEN / 2 + 2);
    localparam logic [CW-1:0] N_FULL = CW'(XLEN / 2 + 1);
    localparam logic [CW-1:0] N_WORD = CW'(WLEN / 2 + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [AW-1:0]   m_q, m_d;
    logic [QW-1:0]   q_q, q_d;
    logic            prev_q, prev_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   n_q, n_d;
    logic            word_q, word_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;

    logic            a_sgn_s, b_sgn_s;
    logic [AW-1:0]   a_ext_s;
    logic [QW-1:0]   b_ext_s;
    logic [AW-1:0]   addend_s;
    logic [QW-1:0]   q_shift_s;
    logic            early_s;

    assign a_sgn_s = mul.in_sign[1];
    assign b_sgn_s = (mul.in_sign == 2'b11);

    // Operand extension; bits above the active width are discarded.
    always_comb begin
        if (mul.in_word) begin
            a_ext_s = {{(AW-WLEN){a_sgn_s & mul.in_a[WLEN-1]}}, mul.in_a[WLEN-1:0]};
            b_ext_s = {{(QW-WLEN){b_sgn_s & mul.in_b[WLEN-1]}}, mul.in_b[WLEN-1:0]};
        end else begin
            a_ext_s = {{(AW-XLEN){a_sgn_s & mul.in_a[XLEN-1]}}, mul.in_a};
            b_ext_s = {{(QW-XLEN){b_sgn_s & mul.in_b[XLEN-1]}}, mul.in_b};
        end
    end

    // Booth digit decode: {Q[1],Q[0],prev} selects 0, +-M or +-2M.
    always_comb begin
        case ({q_q[1:0], prev_q})
            3'b001, 3'b010: addend_s = m_q;
            3'b011:         addend_s = {m_q[AW-2:0], 1'b0};
            3'b100:         addend_s = -{m_q[AW-2:0], 1'b0};
            3'b101, 3'b110: addend_s = -m_q;
            default:        addend_s = {AW{1'b0}};
        endcase
    end

    // Arithmetic shift keeps the upper Q bits equal to the operand sign.
    assign q_shift_s = {{2{q_q[QW-1]}}, q_q[QW-1:2]};

`ifdef YSYX_22050550_MUL_EARLYEXIT_EN
    assign early_s = ((q_shift_s == {QW{1'b0}}) && !q_q[1]) ||
                     ((q_shift_s == {QW{1'b1}}) &&  q_q[1]);
`else
    assign early_s = 1'b0;
`endif

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        m_d     = m_q;
        q_d     = q_q;
        prev_d  = prev_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        word_d  = word_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (mul.in_valid && !mul.flush) begin
                    state_d = S_BUSY;
                    acc_d   = {AW{1'b0}};
                    m_d     = a_ext_s;
                    q_d     = b_ext_s;
                    prev_d  = 1'b0;
                    cnt_d   = {CW{1'b0}};
                    n_d     = mul.in_word ? N_WORD : N_FULL;
                    word_d  = mul.in_word;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (mul.flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == n_q) begin
                    state_d = S_DONE;
                    if (word_q) begin
                        hi_d = {XLEN{1'b0}};
                        lo_d = {{(XLEN-WLEN){acc_q[WLEN-1]}}, acc_q[WLEN-1:0]};
                    end else begin
                        hi_d = acc_q[AW-1:XLEN];
                        lo_d = acc_q[XLEN-1:0];
                    end
                end else begin
                    acc_d  = acc_q + addend_s;
                    m_d    = {m_q[AW-3:0], 2'b00};
                    q_d    = q_shift_s;
                    prev_d = q_q[1];
                    cnt_d  = early_s ? n_q : cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            S_DONE: begin
                if (mul.flush || mul.out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            acc_q   <= {AW{1'b0}};
            m_q     <= {AW{1'b0}};
            q_q     <= {QW{1'b0}};
            prev_q  <= 1'b0;
            cnt_q   <= {CW{1'b0}};
            n_q     <= {CW{1'b0}};
            word_q  <= 1'b0;
            hi_q    <= {XLEN{1'b0}};
            lo_q    <= {XLEN{1'b0}};
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            q_q     <= q_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            word_q  <= word_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign mul.in_ready  = (state_q == S_IDLE);
    assign mul.out_valid = (state_q == S_DONE);
    assign mul.result_hi = hi_q;
    assign mul.result_lo = lo_q;
endmodule
